// File: rtl/mem_arbiter_if.sv
// Line-transaction memory port: one requester (master) driving read/write strobes, address and
// write line, one responder (slave) returning the read line and a one-cycle ready pulse.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 28
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [127:0]      wdata;
  logic [127:0]      rdata;
  logic              ready;

  modport master (output read, output write, output addr, output wdata,
                  input rdata, input ready);
  modport slave  (input read, input write, input addr, input wdata,
                  output rdata, output ready);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I_cache and D_cache line ports, one transaction at a time.
// D wins ties unless it has already won MAX_D_RUN grants in a row while I was waiting.
module mem_arbiter #(
  parameter int unsigned MAX_D_RUN = 4,
  parameter int unsigned ADDR_W    = 28
) (
  input logic           clk,
  input logic           proc_reset,
  mem_arbiter_if.slave  cache_i,
  mem_arbiter_if.slave  cache_d,
  mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD, StRelease} state_e;

  state_e            state_q;
  logic [3:0]        d_run_q;
  logic [ADDR_W-1:0] addr_q;
  logic [127:0]      wdata_q;
  logic              read_q;
  logic              write_q;

  logic req_i, req_d, grant_i, grant_d;

  always_comb begin
    req_i   = cache_i.read | cache_i.write;
    req_d   = cache_d.read | cache_d.write;
    grant_d = req_d & (~req_i | (d_run_q < 4'(MAX_D_RUN)));
    grant_i = req_i & ~grant_d;
  end

  // Strobes are registered; a write request wins over a simultaneous read on the same side.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q <= StIdle;
      d_run_q <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q <= StServeD;
            addr_q  <= cache_d.addr;
            wdata_q <= cache_d.wdata;
            write_q <= cache_d.write;
            read_q  <= ~cache_d.write;
            if (!req_i) begin
              d_run_q <= 4'd0;
            end else if (d_run_q < 4'(MAX_D_RUN)) begin
              d_run_q <= d_run_q + 4'd1;
            end
          end else if (grant_i) begin
            state_q <= StServeI;
            addr_q  <= cache_i.addr;
            wdata_q <= cache_i.wdata;
            write_q <= cache_i.write;
            read_q  <= ~cache_i.write;
            d_run_q <= 4'd0;
          end
        end
        StServeI, StServeD: begin
          if (mem.ready) begin
            state_q <= StRelease;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        StRelease: state_q <= StIdle;
      endcase
    end
  end

  assign mem.read      = read_q;
  assign mem.write     = write_q;
  assign mem.addr      = addr_q;
  assign mem.wdata     = wdata_q;

  assign cache_i.rdata = mem.rdata;
  assign cache_d.rdata = mem.rdata;
  assign cache_i.ready = (state_q == StServeI) & mem.ready;
  assign cache_d.ready = (state_q == StServeD) & mem.ready;

endmodule
